// File: rtl/fifo_rd_checker.sv
// Read-side drain/checker for the 1:2 asymmetric FIFO demo.
// Drives rd_en and checks each wide word against an incrementing 16-bit counter sequence.
module fifo_rd_checker #(
   parameter int HALF_W          = 16,
   parameter int LSB_FIRST       = 1,
   parameter int SEED_FROM_FIRST = 1,
   parameter int SEED            = 1,
   parameter int CNT_W           = 32,
   parameter int ERR_W           = 16
) (
   input  logic                  rd_clk_i,
   input  logic                  rst_i,
   input  logic                  rst_busy_i,
   input  logic                  start_i,
   input  logic                  hold_i,
   input  logic                  empty_i,
   output logic                  rd_en_o,
   input  logic [2*HALF_W-1:0]   rdata_i,
   input  logic                  rd_valid_i,
   output logic [CNT_W-1:0]      word_cnt_o,
   output logic [ERR_W-1:0]      err_cnt_o,
   output logic                  error_o,
   output logic [2*HALF_W-1:0]   err_data_o,
   output logic [2*HALF_W-1:0]   err_exp_o,
   output logic [1:0]            state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ARMED = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   state_t state, state_nxt;

   logic                seeded;
   logic [HALF_W-1:0]   exp_q;
   logic [HALF_W-1:0]   early, late;
   logic [HALF_W-1:0]   exp_cur, exp_plus1;
   logic [2*HALF_W-1:0] exp_word;
   logic                match;
   logic                check_en;

   always_ff @(posedge rd_clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Reset-busy from the FIFO always drops back to IDLE; DRAIN is otherwise terminal.
   always_comb begin
      state_nxt = state;
      if (rst_busy_i) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:  state_nxt = ST_ARMED;
            ST_ARMED: state_nxt = start_i ? ST_DRAIN : ST_ARMED;
            ST_DRAIN: state_nxt = ST_DRAIN;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_en_o = (state == ST_DRAIN) && !empty_i && !hold_i;
      state_o = state;
   end

   always_comb begin
      early     = (LSB_FIRST != 0) ? rdata_i[HALF_W-1:0] : rdata_i[2*HALF_W-1:HALF_W];
      late      = (LSB_FIRST != 0) ? rdata_i[2*HALF_W-1:HALF_W] : rdata_i[HALF_W-1:0];
      exp_cur   = ((SEED_FROM_FIRST != 0) && !seeded) ? early : exp_q;
      exp_plus1 = exp_cur + HALF_W'(1);
      exp_word  = (LSB_FIRST != 0) ? {exp_plus1, exp_cur} : {exp_cur, exp_plus1};
      match     = (early == exp_cur) && (late == exp_plus1);
      check_en  = rd_valid_i && (state != ST_IDLE) && !rst_busy_i;
   end

   // The expectation always advances by one word, so a single bad word yields a single error.
   always_ff @(posedge rd_clk_i) begin
      if (rst_i) begin
         seeded     <= 1'b0;
         exp_q      <= HALF_W'(SEED);
         word_cnt_o <= '0;
         err_cnt_o  <= '0;
         error_o    <= 1'b0;
         err_data_o <= '0;
         err_exp_o  <= '0;
      end else if (rst_busy_i) begin
         seeded <= 1'b0;
      end else if (check_en) begin
         seeded <= 1'b1;
         exp_q  <= exp_cur + HALF_W'(2);
         if (word_cnt_o != {CNT_W{1'b1}}) begin
            word_cnt_o <= word_cnt_o + CNT_W'(1);
         end
         if (!match) begin
            error_o <= 1'b1;
            if (err_cnt_o != {ERR_W{1'b1}}) begin
               err_cnt_o <= err_cnt_o + ERR_W'(1);
            end
            if (!error_o) begin
               err_data_o <= rdata_i;
               err_exp_o  <= exp_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Self-checking bench for fifo_rd_checker: scoreboard of expected counters per driven word,
// plus per-scenario checks of FSM state, read enable gating and mismatch capture.
module tb_fifo_rd_checker;

   logic        rd_clk = 1'b0;
   logic        rst, rst_busy, start, hold, empty, rd_en, rd_valid, error;
   logic [31:0] rdata, word_cnt, err_data, err_exp;
   logic [15:0] err_cnt;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] wc;
      logic [15:0] ec;
      logic        er;
   } score_t;

   score_t sb[$];

   bit          m_seeded;
   logic [15:0] m_exp;
   logic [31:0] m_wc;
   logic [15:0] m_ec;
   logic        m_err;

   always #5 rd_clk = ~rd_clk;

   fifo_rd_checker #(
      .HALF_W(16), .LSB_FIRST(1), .SEED_FROM_FIRST(1), .SEED(1), .CNT_W(32), .ERR_W(16)
   ) dut (
      .rd_clk_i   (rd_clk),
      .rst_i      (rst),
      .rst_busy_i (rst_busy),
      .start_i    (start),
      .hold_i     (hold),
      .empty_i    (empty),
      .rd_en_o    (rd_en),
      .rdata_i    (rdata),
      .rd_valid_i (rd_valid),
      .word_cnt_o (word_cnt),
      .err_cnt_o  (err_cnt),
      .error_o    (error),
      .err_data_o (err_data),
      .err_exp_o  (err_exp),
      .state_o    (state)
   );

   task automatic model_reset();
      m_seeded = 1'b0;
      m_exp    = 16'd1;
      m_wc     = '0;
      m_ec     = '0;
      m_err    = 1'b0;
   endtask

   // Advances the reference model for one driven word and queues the counters expected after it.
   task automatic push_word(input logic [31:0] w, input bit counted);
      logic [15:0] e, l;
      score_t      s;
      e = w[15:0];
      l = w[31:16];
      if (counted) begin
         if (!m_seeded) begin
            m_exp    = e;
            m_seeded = 1'b1;
         end
         if (!((e == m_exp) && (l == m_exp + 16'd1))) begin
            m_ec  = m_ec + 16'd1;
            m_err = 1'b1;
         end
         m_exp = m_exp + 16'd2;
         m_wc  = m_wc + 32'd1;
      end
      s.wc = m_wc;
      s.ec = m_ec;
      s.er = m_err;
      sb.push_back(s);
   endtask

   task automatic feed(input logic [31:0] w, input bit counted);
      @(negedge rd_clk);
      rdata    = w;
      rd_valid = 1'b1;
      push_word(w, counted);
   endtask

   task automatic end_feed();
      @(negedge rd_clk);
      rd_valid = 1'b0;
      @(negedge rd_clk);
   endtask

   task automatic do_reset();
      @(negedge rd_clk);
      rst      = 1'b1;
      rst_busy = 1'b1;
      rd_valid = 1'b0;
      start    = 1'b0;
      hold     = 1'b0;
      empty    = 1'b0;
      @(negedge rd_clk);
      @(negedge rd_clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic arm_and_start();
      @(negedge rd_clk);
      rst_busy = 1'b0;
      @(negedge rd_clk);
      start = 1'b1;
      @(negedge rd_clk);
      start = 1'b0;
   endtask

   // Scoreboard consumer: every edge that sampled rd_valid owns one queued expectation.
   always @(posedge rd_clk) begin : monitor
      logic   v;
      score_t s;
      v = rd_valid;
      #2;
      if (v) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_underflow: word seen with no expectation queued");
         end else begin
            s = sb.pop_front();
            if (word_cnt !== s.wc || err_cnt !== s.ec || error !== s.er) begin
               errors++;
               $display("[TB] FAIL sb_counters: got wc=%0d ec=%0d err=%0b, want wc=%0d ec=%0d err=%0b",
                        word_cnt, err_cnt, error, s.wc, s.ec, s.er);
            end
         end
      end
   end

   task automatic test_reset();
      do_reset();
      arm_and_start();
      feed(32'h0002_0001, 1'b1);
      feed(32'h0000_0000, 1'b1);
      feed(32'h0006_0005, 1'b1);
      end_feed();
      @(negedge rd_clk);
      rst = 1'b1;
      @(negedge rd_clk);
      @(negedge rd_clk);
      #1;
      checks++;
      if (state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state: got %b want 00", state); end
      checks++;
      if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %b want 0", rd_en); end
      checks++;
      if (word_cnt !== 32'd0 || err_cnt !== 16'd0 || error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_counters: got wc=%0d ec=%0d err=%b want 0/0/0", word_cnt, err_cnt, error);
      end
      checks++;
      if (err_data !== 32'd0 || err_exp !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_capture: got data=%h exp=%h want 0/0", err_data, err_exp);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_normal();
      do_reset();
      arm_and_start();
      #1;
      checks++;
      if (state !== 2'b10 || rd_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL normal_drain: got state=%b rd_en=%b want 10/1", state, rd_en);
      end
      for (int i = 0; i < 100; i++) begin
         feed({16'(2 * i + 2), 16'(2 * i + 1)}, 1'b1);
      end
      end_feed();
      #1;
      checks++;
      if (word_cnt !== 32'd100 || err_cnt !== 16'd0 || error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL normal_totals: got wc=%0d ec=%0d err=%b want 100/0/0", word_cnt, err_cnt, error);
      end
   endtask

   task automatic test_corrupt();
      do_reset();
      arm_and_start();
      for (int i = 0; i < 10; i++) begin
         feed((i == 4) ? 32'h000A_000A : {16'(2 * i + 2), 16'(2 * i + 1)}, 1'b1);
      end
      end_feed();
      #1;
      checks++;
      if (error !== 1'b1 || err_cnt !== 16'd1 || word_cnt !== 32'd10) begin
         errors++;
         $display("[TB] FAIL corrupt_counts: got err=%b ec=%0d wc=%0d want 1/1/10", error, err_cnt, word_cnt);
      end
      checks++;
      if (err_data !== 32'h000A_000A) begin
         errors++;
         $display("[TB] FAIL corrupt_err_data: got %h want 000a000a", err_data);
      end
      checks++;
      if (err_exp !== 32'h000A_0009) begin
         errors++;
         $display("[TB] FAIL corrupt_err_exp: got %h want 000a0009", err_exp);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      arm_and_start();
      feed(32'hFFFE_FFFD, 1'b1);
      feed(32'h0000_FFFF, 1'b1);
      feed(32'h0002_0001, 1'b1);
      end_feed();
      #1;
      checks++;
      if (err_cnt !== 16'd0 || word_cnt !== 32'd3 || error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrap_totals: got ec=%0d wc=%0d err=%b want 0/3/0", err_cnt, word_cnt, error);
      end
   endtask

   task automatic test_gating();
      do_reset();
      @(negedge rd_clk);
      start = 1'b1;
      @(negedge rd_clk);
      @(negedge rd_clk);
      #1;
      checks++;
      if (state !== 2'b00 || rd_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL gate_busy_start: got state=%b rd_en=%b want 00/0", state, rd_en);
      end
      start    = 1'b0;
      rst_busy = 1'b0;
      @(negedge rd_clk);
      #1;
      checks++;
      if (state !== 2'b01 || rd_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL gate_armed: got state=%b rd_en=%b want 01/0", state, rd_en);
      end
      start = 1'b1;
      @(negedge rd_clk);
      start = 1'b0;
      #1;
      checks++;
      if (state !== 2'b10 || rd_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL gate_drain: got state=%b rd_en=%b want 10/1", state, rd_en);
      end
      empty = 1'b1;
      #1;
      checks++;
      if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL gate_empty: got %b want 0", rd_en); end
      empty = 1'b0;
      hold  = 1'b1;
      #1;
      checks++;
      if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL gate_hold: got %b want 0", rd_en); end
      hold = 1'b0;
      #1;
      checks++;
      if (rd_en !== 1'b1) begin errors++; $display("[TB] FAIL gate_release: got %b want 1", rd_en); end
   endtask

   task automatic test_busy_discard();
      do_reset();
      arm_and_start();
      feed(32'h0002_0001, 1'b1);
      feed(32'h0004_0003, 1'b1);
      feed(32'h0006_0005, 1'b1);
      @(negedge rd_clk);
      rst_busy = 1'b1;
      rdata    = 32'h1234_5678;
      rd_valid = 1'b1;
      push_word(32'h1234_5678, 1'b0);
      @(negedge rd_clk);
      rd_valid = 1'b0;
      #1;
      checks++;
      if (state !== 2'b00 || word_cnt !== 32'd3 || err_cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL busy_discard: got state=%b wc=%0d ec=%0d want 00/3/0", state, word_cnt, err_cnt);
      end
      m_seeded = 1'b0;
      arm_and_start();
      feed(32'h0010_000F, 1'b1);
      feed(32'h0012_0011, 1'b1);
      end_feed();
      #1;
      checks++;
      if (error !== 1'b0 || err_cnt !== 16'd0 || word_cnt !== 32'd5) begin
         errors++;
         $display("[TB] FAIL busy_reseed: got err=%b ec=%0d wc=%0d want 0/0/5", error, err_cnt, word_cnt);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      rst_busy = 1'b1;
      start    = 1'b0;
      hold     = 1'b0;
      empty    = 1'b0;
      rd_valid = 1'b0;
      rdata    = '0;
      model_reset();
      test_reset();
      test_normal();
      test_corrupt();
      test_wrap();
      test_gating();
      test_busy_discard();
      @(negedge rd_clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
